// File: rtl/haar_cascade_stage_sequencer.sv
// Per-window sequencer for the second-phase Haar cascade stages.
// It walks the stage databases in order with one-hot read enables.
// It waits for the evaluator verdict on each stage and rejects a window at
// the first failing stage.
// Optional feature macro: HAAR_SEQ_WATCHDOG_EN. It adds an EVAL timeout of
// WATCHDOG_CYCLES cycles that ends the window with o_error=1.
// reset_fpga is an asynchronous, active-low reset.

module haar_cascade_stage_sequencer #(
  parameter int NUM_STAGES      = 8,
  parameter int STAGE_W         = 4,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NUM_STAGES-1:0] i_end_count_database_index,
  input  logic                  i_eval_done,
  input  logic                  i_stage_pass,
  output logic                  o_busy,
  output logic                  o_db_clear,
  output logic [NUM_STAGES-1:0] o_rden,
  output logic [STAGE_W-1:0]    o_stage_index,
  output logic                  o_result_valid,
  output logic                  o_face_detected,
  output logic [STAGE_W-1:0]    o_fail_stage,
  output logic                  o_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t state_reg;

  // One-hot decode of the current stage and of the following stage.
  // Using masks avoids indexing the flag vector with an over-wide index.
  logic [NUM_STAGES-1:0] cur_sel;
  logic [NUM_STAGES-1:0] inc_sel;
  logic [STAGE_W-1:0]    stage_inc;
  logic                  end_flag;
  logic                  last_stage;

  assign stage_inc = o_stage_index + STAGE_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_sel
      assign cur_sel[gi] = (o_stage_index == STAGE_W'(gi));
      assign inc_sel[gi] = (stage_inc == STAGE_W'(gi));
    end
  endgenerate

  // Only the active stage's end-of-database flag matters.
  assign end_flag   = |(i_end_count_database_index & cur_sel);
  assign last_stage = (o_stage_index == STAGE_W'(NUM_STAGES - 1));

`ifdef HAAR_SEQ_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  logic [WD_W-1:0] wd_count_reg;
  logic            wd_expired;

  assign wd_expired = (wd_count_reg == WD_W'(WATCHDOG_CYCLES - 1));
`else
  // Without the watchdog, EVAL waits indefinitely and no error is ever raised.
  assign o_error = 1'b0;

  // Keeps the timeout parameter referenced in the build without a watchdog.
  logic unused_cfg;
  assign unused_cfg = ^WATCHDOG_CYCLES;
`endif

  // Window FSM; every output is registered alongside the state.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_reg       <= ST_IDLE;
      o_busy          <= 1'b0;
      o_db_clear      <= 1'b0;
      o_rden          <= '0;
      o_stage_index   <= '0;
      o_result_valid  <= 1'b0;
      o_face_detected <= 1'b0;
      o_fail_stage    <= '0;
`ifdef HAAR_SEQ_WATCHDOG_EN
      o_error         <= 1'b0;
      wd_count_reg    <= '0;
`endif
    end else begin
      // These two are pulses and default low every cycle.
      o_db_clear     <= 1'b0;
      o_result_valid <= 1'b0;

      if (i_abort) begin
        // Abort drops the window silently.
        // The result and stage outputs keep their values.
        state_reg <= ST_IDLE;
        o_busy    <= 1'b0;
        o_rden    <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (i_start) begin
              state_reg     <= ST_CLEAR;
              o_busy        <= 1'b1;
              o_db_clear    <= 1'b1;
              o_stage_index <= '0;
            end
          end

          ST_CLEAR: begin
            // The index is already 0, so cur_sel selects stage 0.
            state_reg <= ST_FETCH;
            o_rden    <= cur_sel;
          end

          ST_FETCH: begin
            // The enable stays high through the cycle that reads the last word.
            if (end_flag) begin
              state_reg <= ST_EVAL;
              o_rden    <= '0;
`ifdef HAAR_SEQ_WATCHDOG_EN
              wd_count_reg <= '0;
`endif
            end
          end

          ST_EVAL: begin
            if (i_eval_done) begin
              // A verdict arriving in the timeout cycle still takes effect.
              if (i_stage_pass && !last_stage) begin
                // Move straight to the next stage. Its database was already
                // rewound at window start, so no CLEAR is needed.
                state_reg     <= ST_FETCH;
                o_stage_index <= stage_inc;
                o_rden        <= inc_sel;
              end else begin
                state_reg       <= ST_DONE;
                o_result_valid  <= 1'b1;
                o_face_detected <= i_stage_pass;
                o_fail_stage    <= i_stage_pass ? STAGE_W'(NUM_STAGES) : o_stage_index;
`ifdef HAAR_SEQ_WATCHDOG_EN
                o_error         <= 1'b0;
`endif
              end
`ifdef HAAR_SEQ_WATCHDOG_EN
            end else if (wd_expired) begin
              state_reg       <= ST_DONE;
              o_result_valid  <= 1'b1;
              o_face_detected <= 1'b0;
              o_fail_stage    <= STAGE_W'(NUM_STAGES);
              o_error         <= 1'b1;
            end else begin
              wd_count_reg <= wd_count_reg + WD_W'(1);
`endif
            end
          end

          ST_DONE: begin
            // A start request is considered no earlier than the next cycle.
            state_reg <= ST_IDLE;
            o_busy    <= 1'b0;
          end

          default: begin
            state_reg <= ST_IDLE;
            o_busy    <= 1'b0;
            o_rden    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/haar_cascade_stage_sequencer.md
Name: haar_cascade_stage_sequencer

Overview:
- Per-window controller for the second-phase Haar cascade (stages 4..11, stage slots 0..NUM_STAGES-1).
- Accepts a candidate window and streams each stage database in order via per-stage read enables.
- Waits for the stage evaluator's pass/fail verdict and rejects early on the first failing stage.
- Sits between the window scanner and the per-stage database FIFOs / stage evaluator.

Parameters:
- NUM_STAGES, 8, number of second-phase stages sequenced.
- STAGE_W, 4, width of the stage index; must satisfy 2^STAGE_W > NUM_STAGES.
- WATCHDOG_CYCLES, 1024, EVAL timeout in cycles; used only with the optional feature.

Ports:
- clk_fpga  in  1  system clock.
- reset_fpga  in  1  asynchronous active-low reset.
- i_start  in  1  window-start request; sampled only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE from any state.
- i_end_count_database_index  in  NUM_STAGES  per-stage "last database word read" flags.
- i_eval_done  in  1  evaluator verdict strobe for the current stage.
- i_stage_pass  in  1  verdict; qualified by i_eval_done.
- o_busy  out  1  high in every state except IDLE.
- o_db_clear  out  1  one-cycle pulse that rewinds all database counters at window start.
- o_rden  out  NUM_STAGES  one-hot read enable of the active stage database.
- o_stage_index  out  STAGE_W  stage currently fetched or evaluated.
- o_result_valid  out  1  one-cycle result strobe.
- o_face_detected  out  1  1 = all stages passed; valid with o_result_valid.
- o_fail_stage  out  STAGE_W  first failing stage; NUM_STAGES when passed or timed out.
- o_error  out  1  watchdog abort flag; valid with o_result_valid.

Behaviour:
- Reset (reset_fpga=0, async): state=IDLE.
  - All outputs 0, except o_fail_stage=0 and o_stage_index=0.
- States: IDLE, CLEAR, FETCH, EVAL, DONE.
- IDLE:
  - o_busy=0.
  - i_start=1 -> CLEAR; o_stage_index<=0.
- CLEAR:
  - o_db_clear=1 for exactly one cycle -> FETCH.
- FETCH:
  - o_rden[o_stage_index]=1; all other bits 0.
  - Stays in FETCH while i_end_count_database_index[o_stage_index]=0.
  - When that flag is sampled 1, o_rden still 1 that cycle (last word read) -> EVAL.
  - o_rden registered; drops to 0 on the first EVAL cycle.
- EVAL:
  - o_rden=0. Waits for i_eval_done.
  - i_eval_done & i_stage_pass & o_stage_index==NUM_STAGES-1 -> DONE, pass.
  - i_eval_done & i_stage_pass & o_stage_index<NUM_STAGES-1 -> o_stage_index+1, FETCH (no CLEAR between stages).
  - i_eval_done & !i_stage_pass -> DONE, fail; o_fail_stage<=o_stage_index.
- DONE:
  - o_result_valid=1 for one cycle; o_face_detected and o_fail_stage held until the next DONE.
  - Next state IDLE. A fresh i_start is honoured no earlier than the cycle after DONE.
- Latency:
  - Minimum start-to-result = 2 + sum over stages visited of (fetch cycles + eval wait + 1).
  - Single-stage reject with a 1-cycle fetch and immediate verdict: i_start at cycle 0, o_result_valid at cycle 4.
- Simultaneous events:
  - i_abort has priority over everything: -> IDLE, o_rden=0, no o_result_valid, outputs otherwise unchanged.
  - i_start while busy: ignored, not queued.
  - i_eval_done in FETCH/IDLE/CLEAR: ignored.
  - End-count flags of non-active stages: ignored.
- Reset mid-window: immediate IDLE; no result emitted.

Optional Feature:
- Macro: HAAR_SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in EVAL and clears on entry to EVAL.
  - If it reaches WATCHDOG_CYCLES-1 without i_eval_done -> DONE with o_error=1, o_face_detected=0, o_fail_stage=NUM_STAGES.
  - i_eval_done in the same cycle as the timeout wins (normal verdict).
- Not defined:
  - No counter is present; o_error is tied to 0; EVAL waits indefinitely.

Test Plan:
- All-pass: i_start; each stage end flag after 3 cycles; i_eval_done&pass 2 cycles into EVAL.
  - Expect o_rden one-hot walking 0x01..0x80, a single o_db_clear pulse, then o_result_valid with o_face_detected=1, o_fail_stage=8.
- Early reject at stage 2: pass stages 0 and 1, fail stage 2.
  - Expect o_result_valid, o_face_detected=0, o_fail_stage=2; o_rden bits 3..7 never asserted.
- Abort mid-FETCH of stage 5: i_abort=1.
  - Expect IDLE next cycle, o_rden=0x00, no o_result_valid; a new i_start runs normally.
- Start while busy: i_start pulsed during EVAL of stage 1.
  - Expect it ignored: exactly one o_result_valid.
- Async reset asserted in EVAL between clock edges.
  - Expect outputs 0 before the next edge and state=IDLE.
- With HAAR_SEQ_WATCHDOG_EN and WATCHDOG_CYCLES=16: withhold i_eval_done in stage 0.
  - Expect o_result_valid 16 cycles after EVAL entry with o_error=1, o_fail_stage=8.
